// File: rtl/uart_mem_cmd_decoder.sv
// uart_mem_cmd_decoder
//
// Host-side command responder for the LUT-RAM test designs. Decodes byte frames
// arriving from a UART receiver, drives one read/write port of a distributed RAM
// and returns a single response byte on the UART transmit handshake.
//
//   Write frame: 'W' (0x57), addr, data -> response 'K' (0x4B)
//   Read frame : 'R' (0x52), addr       -> response {zero-extend, mem_read_data}
//   Bad opcode -> '?' (0x3F); address above ADDR_WIDTH bits -> 'E' (0x45)
//
// Ports
//   clk, nrst          clock (rising edge), asynchronous active-low reset
//   rx_data/_ready     received byte and its one-cycle strobe
//   tx_data/_ready     response byte, held valid until tx_data_accepted
//   tx_data_accepted   UART has taken tx_data this cycle
//   mem_address        RAM address (held between commands)
//   mem_write_data     RAM write data (held between commands)
//   mem_write_enable   single-cycle RAM write strobe
//   mem_read_data      asynchronous RAM read of mem_address
//   overrun            sticky: a byte arrived while busy executing/responding
//   cmd_count          number of accepted responses, wraps at 8 bits
module uart_mem_cmd_decoder #(
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned DATA_WIDTH     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_data_ready,
  input  logic                  tx_data_accepted,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  overrun,
  output logic [7:0]            cmd_count
);

  localparam logic [7:0] OpWrite  = 8'h57;
  localparam logic [7:0] OpRead   = 8'h52;
  localparam logic [7:0] RespBad  = 8'h3F;
  localparam logic [7:0] RespErr  = 8'h45;
  localparam logic [7:0] RespOk   = 8'h4B;

  localparam int unsigned TimeoutW =
      (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TimeoutW-1:0] TimeoutLim = TimeoutW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StExecWr,
    StExecRd,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic                  is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]            tx_q, tx_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            cmd_count_q, cmd_count_d;
  logic [TimeoutW-1:0]   tmo_q, tmo_d;

  logic [TimeoutW-1:0]   tmo_inc;
  logic                  timed_out;

  // Idle-cycle counter used only while waiting for the remaining bytes of a frame.
  assign tmo_inc   = tmo_q + 1'b1;
  assign timed_out = (TIMEOUT_CYCLES != 0) && (tmo_inc == TimeoutLim);

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tx_d        = tx_q;
    overrun_d   = overrun_q;
    cmd_count_d = cmd_count_q;
    tmo_d       = tmo_q;

    unique case (state_q)
      StIdle: begin
        if (rx_data_ready) begin
          if (rx_data == OpWrite || rx_data == OpRead) begin
            is_wr_d = (rx_data == OpWrite);
            tmo_d   = '0;
            state_d = StGetAddr;
          end else begin
            tx_d    = RespBad;
            state_d = StResp;
          end
        end
      end

      StGetAddr: begin
        if (rx_data_ready) begin
          tmo_d = '0;
          // Any set bit above the RAM address width is an out-of-range address.
          if ((rx_data >> ADDR_WIDTH) != 8'd0) begin
            tx_d    = RespErr;
            state_d = StResp;
          end else begin
            addr_d  = rx_data[ADDR_WIDTH-1:0];
            state_d = is_wr_q ? StGetData : StExecRd;
          end
        end else if (timed_out) begin
          tmo_d   = '0;
          state_d = StIdle;
        end else if (TIMEOUT_CYCLES != 0) begin
          tmo_d = tmo_inc;
        end
      end

      StGetData: begin
        if (rx_data_ready) begin
          tmo_d   = '0;
          wdata_d = rx_data[DATA_WIDTH-1:0];
          state_d = StExecWr;
        end else if (timed_out) begin
          tmo_d   = '0;
          state_d = StIdle;
        end else if (TIMEOUT_CYCLES != 0) begin
          tmo_d = tmo_inc;
        end
      end

      StExecWr: begin
        if (rx_data_ready) overrun_d = 1'b1;
        tx_d    = RespOk;
        state_d = StResp;
      end

      StExecRd: begin
        if (rx_data_ready) overrun_d = 1'b1;
        tx_d    = 8'(mem_read_data);
        state_d = StResp;
      end

      StResp: begin
        // A byte arriving alongside the accept is still dropped, never decoded.
        if (rx_data_ready) overrun_d = 1'b1;
        if (tx_data_accepted) begin
          cmd_count_d = cmd_count_q + 8'd1;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tx_q        <= 8'd0;
      overrun_q   <= 1'b0;
      cmd_count_q <= 8'd0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tx_q        <= tx_d;
      overrun_q   <= overrun_d;
      cmd_count_q <= cmd_count_d;
      tmo_q       <= tmo_d;
    end
  end

  // Strobes decode straight from the state register so reset clears them at once.
  assign mem_write_enable = (state_q == StExecWr);
  assign tx_data_ready    = (state_q == StResp);
  assign tx_data          = tx_q;
  assign mem_address      = addr_q;
  assign mem_write_data   = wdata_q;
  assign overrun          = overrun_q;
  assign cmd_count        = cmd_count_q;

endmodule

// File: tb/tb_uart_mem_cmd_decoder.sv
// Self-checking bench for uart_mem_cmd_decoder: directed scenarios followed by
// random frames, compared against a frame-level reference model of the RAM and
// the expected response/latency of each command.
module tb_uart_mem_cmd_decoder;

  localparam int unsigned AW  = 6;
  localparam int unsigned DW  = 1;
  localparam int unsigned TMO = 100;
  localparam int unsigned Depth = 1 << AW;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_data_ready = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_data_ready;
  logic          tx_data_accepted = 1'b0;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_enable;
  logic [DW-1:0] mem_read_data;
  logic          overrun;
  logic [7:0]    cmd_count;

  // Distributed RAM attached to the DUT, plus the bench's own expected contents.
  logic [DW-1:0] ram     [Depth];
  logic [DW-1:0] ref_mem [Depth];

  int n_cmp = 0;
  int n_err = 0;
  int wr_count = 0;
  int model_cmd = 0;

  always #5 clk = ~clk;

  uart_mem_cmd_decoder #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk             (clk),
    .nrst            (nrst),
    .rx_data         (rx_data),
    .rx_data_ready   (rx_data_ready),
    .tx_data         (tx_data),
    .tx_data_ready   (tx_data_ready),
    .tx_data_accepted(tx_data_accepted),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_write_enable(mem_write_enable),
    .mem_read_data   (mem_read_data),
    .overrun         (overrun),
    .cmd_count       (cmd_count)
  );

  assign mem_read_data = ram[mem_address];

  always @(posedge clk) begin
    if (mem_write_enable) begin
      wr_count = wr_count + 1;
      ram[mem_address] <= mem_write_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; strobe is high for the following rising edge only.
  task automatic send_byte(input logic [7:0] b);
    rx_data       = b;
    rx_data_ready = 1'b1;
    @(negedge clk);
    rx_data_ready = 1'b0;
    rx_data       = 8'($urandom);
  endtask

  task automatic accept_resp();
    tx_data_accepted = 1'b1;
    @(negedge clk);
    tx_data_accepted = 1'b0;
    model_cmd++;
    check("rdy_drop", tx_data_ready, 1'b0);
    check("cmd_count", cmd_count, 8'(model_cmd));
  endtask

  // Send one frame, check latency, write side effects and response, then accept.
  task automatic run_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                           input int gap, input int hold);
    logic [7:0] exp;
    int lat, nb, wr0;
    logic exp_wr;
    exp_wr = 1'b0;
    if (op != 8'h57 && op != 8'h52) begin
      exp = 8'h3F; lat = 1; nb = 1;
    end else if (int'(a) >= int'(Depth)) begin
      exp = 8'h45; lat = 1; nb = 2;
    end else if (op == 8'h57) begin
      exp = 8'h4B; lat = 2; nb = 3; exp_wr = 1'b1;
    end else begin
      exp = 8'(ref_mem[a[AW-1:0]]); lat = 2; nb = 2;
    end
    wr0 = wr_count;
    send_byte(op);
    if (nb > 1) begin
      if (nb == 2) repeat (gap) @(negedge clk);
      send_byte(a);
    end
    if (nb > 2) begin
      repeat (gap) @(negedge clk);
      send_byte(d);
    end
    check("rdy_cycle1", tx_data_ready, (lat == 1));
    if (exp_wr) begin
      check("we_cycle1", mem_write_enable, 1'b1);
      check("we_addr", mem_address, a[AW-1:0]);
      check("we_data", mem_write_data, d[DW-1:0]);
      ref_mem[a[AW-1:0]] = d[DW-1:0];
    end else begin
      check("we_quiet", mem_write_enable, 1'b0);
    end
    if (lat == 2) begin
      @(negedge clk);
      check("rdy_cycle2", tx_data_ready, 1'b1);
      check("we_cycle2", mem_write_enable, 1'b0);
    end
    check("resp", tx_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rdy", tx_data_ready, 1'b1);
      check("hold_data", tx_data, exp);
    end
    check("wr_pulses", wr_count - wr0, exp_wr);
    accept_resp();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx"}, tx_data, 8'd0);
    check({tag, "_rdy"}, tx_data_ready, 1'b0);
    check({tag, "_addr"}, mem_address, '0);
    check({tag, "_wdata"}, mem_write_data, '0);
    check({tag, "_we"}, mem_write_enable, 1'b0);
    check({tag, "_ovr"}, overrun, 1'b0);
    check({tag, "_cnt"}, cmd_count, 8'd0);
  endtask

  initial begin
    logic [7:0] exp_rd;
    int wr0;
    for (int i = 0; i < int'(Depth); i++) begin
      ram[i]     = DW'($urandom);
      ref_mem[i] = ram[i];
    end

    // Reset state
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Write then read back
    run_frame(8'h57, 8'h05, 8'h01, 0, 0);
    run_frame(8'h52, 8'h05, 8'h00, 0, 2);
    check("cmd_after_wr_rd", cmd_count, 8'd2);

    // Bad opcode, then normal read of address 0
    run_frame(8'h41, 8'h00, 8'h00, 0, 0);
    run_frame(8'h52, 8'h00, 8'h00, 0, 0);

    // Out-of-range address, then read back the alias location
    run_frame(8'h57, 8'h40, 8'h01, 0, 0);
    run_frame(8'h52, 8'h00, 8'h00, 0, 0);

    // Timeout: half a frame followed by TMO idle cycles is abandoned silently
    wr0 = wr_count;
    send_byte(8'h57);
    send_byte(8'h05);
    repeat (TMO) @(negedge clk);
    check("tmo_no_resp", tx_data_ready, 1'b0);
    check("tmo_no_write", wr_count - wr0, 0);
    check("tmo_cmd", cmd_count, 8'(model_cmd));
    run_frame(8'h52, 8'h05, 8'h00, 0, 0);
    // One cycle short of the limit the frame must still complete
    run_frame(8'h57, 8'h06, 8'h01, int'(TMO) - 1, 0);
    run_frame(8'h52, 8'h06, 8'h00, 0, 0);

    // Backpressure with a byte injected while the response is pending
    exp_rd = 8'(ref_mem[5]);
    check("ovr_before", overrun, 1'b0);
    send_byte(8'h52);
    send_byte(8'h05);
    @(negedge clk);
    check("bp_rdy", tx_data_ready, 1'b1);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) send_byte(8'h57);
      else @(negedge clk);
      if (i == 0 || i == 11 || i == 49) begin
        check("bp_hold_rdy", tx_data_ready, 1'b1);
        check("bp_hold_data", tx_data, exp_rd);
      end
    end
    check("ovr_set", overrun, 1'b1);
    accept_resp();
    run_frame(8'h52, 8'h05, 8'h00, 0, 0);
    check("ovr_sticky", overrun, 1'b1);

    // Reset mid-frame
    send_byte(8'h57);
    send_byte(8'h05);
    nrst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    model_cmd = 0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    run_frame(8'h52, 8'h05, 8'h00, 0, 0);

    // Reset with a response pending drops tx_data_ready immediately
    send_byte(8'h3A);
    check("pend_rdy", tx_data_ready, 1'b1);
    nrst = 1'b0;
    #1;
    check("rst_rdy_drop", tx_data_ready, 1'b0);
    model_cmd = 0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Byte during EXEC_RD is dropped and flags overrun
    exp_rd = 8'(ref_mem[9]);
    send_byte(8'h52);
    send_byte(8'h09);
    send_byte(8'h41);
    check("exec_rdy", tx_data_ready, 1'b1);
    check("exec_resp", tx_data, exp_rd);
    check("exec_ovr", overrun, 1'b1);
    accept_resp();

    // Byte in the same cycle as the accept is dropped
    send_byte(8'h20);
    tx_data_accepted = 1'b1;
    rx_data          = 8'h41;
    rx_data_ready    = 1'b1;
    @(negedge clk);
    tx_data_accepted = 1'b0;
    rx_data_ready    = 1'b0;
    model_cmd++;
    check("same_cyc_rdy", tx_data_ready, 1'b0);
    check("same_cyc_cnt", cmd_count, 8'(model_cmd));
    run_frame(8'h52, 8'h03, 8'h00, 0, 0);

    // Random frames
    for (int n = 0; n < 80; n++) begin
      int sel;
      logic [7:0] op, a, d;
      sel = int'($urandom_range(0, 9));
      a   = 8'($urandom_range(0, Depth - 1));
      d   = 8'($urandom);
      if (sel == 0) begin
        do op = 8'($urandom); while (op == 8'h57 || op == 8'h52);
      end else if (sel == 1) begin
        op = 8'h57;
        a  = 8'($urandom_range(Depth, 255));
      end else if (sel < 6) begin
        op = 8'h57;
      end else begin
        op = 8'h52;
      end
      run_frame(op, a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_mem_cmd_decoder.md
Name: uart_mem_cmd_decoder

Overview:
- Host-side command responder for the LUT-RAM test designs.
- Consumes bytes from the UART receive interface and decodes read/write command frames.
- Drives one read/write port of a distributed RAM (e.g. RAM64X1D A/D/WE with DPO read-back).
- Returns a one-byte response on the UART transmit handshake.
- Lets a PC poke and peek the memory under test.

Parameters:
- ADDR_WIDTH, 6, RAM address width; must be 1..8.
- DATA_WIDTH, 1, RAM data width; must be 1..8.
- TIMEOUT_CYCLES, 1000000, clk cycles allowed between bytes of one frame; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- rx_data  input  8  received byte; valid when rx_data_ready=1.
- rx_data_ready  input  1  one-cycle strobe per received byte.
- tx_data  output  8  response byte.
- tx_data_ready  output  1  response valid; held until accepted.
- tx_data_accepted  input  1  UART has taken tx_data this cycle.
- mem_address  output  ADDR_WIDTH  RAM address.
- mem_write_data  output  DATA_WIDTH  RAM write data.
- mem_write_enable  output  1  RAM write strobe.
- mem_read_data  input  DATA_WIDTH  RAM read data (asynchronous LUT read of mem_address).
- overrun  output  1  sticky: a byte arrived while a response was pending.
- cmd_count  output  8  count of completed commands (responses accepted), wraps 255->0.

Behaviour:
- Reset (nrst=0, asynchronous):
  - State IDLE.
  - All outputs 0; timeout counter 0.
  - Any partial frame is discarded and no write occurs.
  - tx_data_ready drops immediately.
- Frames:
  - Write: 0x57 'W', addr, data.
  - Read: 0x52 'R', addr.
- States:
  - IDLE: on strobe, 0x57/0x52 -> GET_ADDR with the opcode latched. Any other byte -> RESP with tx_data=0x3F '?'.
  - GET_ADDR: on strobe, if addr[7:ADDR_WIDTH]!=0 -> RESP with 0x45 'E'. Else latch mem_address=addr[ADDR_WIDTH-1:0]; 'W' -> GET_DATA, 'R' -> EXEC_RD.
  - GET_DATA: on strobe, mem_write_data=data[DATA_WIDTH-1:0] (upper bits ignored) -> EXEC_WR.
  - EXEC_WR: mem_write_enable=1 for exactly this one cycle -> RESP with 0x4B 'K'.
  - EXEC_RD: mem_address stable; register tx_data={zero-extend, mem_read_data} at cycle end -> RESP.
  - RESP: tx_data_ready=1 and tx_data stable. On tx_data_accepted: tx_data_ready=0 next cycle, cmd_count+1, -> IDLE.
- Latency, counted from the cycle in which the final byte's strobe is high (cycle 0):
  - Write: mem_write_enable high in cycle 1; tx_data_ready high from cycle 2.
  - Read: tx_data_ready high from cycle 2.
  - Error responses ('?', 'E'): tx_data_ready high from cycle 1.
- Timeout:
  - The counter runs only in GET_ADDR/GET_DATA.
  - It clears on each strobe and on entry to those states.
  - On reaching TIMEOUT_CYCLES: -> IDLE silently, no write, no response, cmd_count unchanged.
- Bytes during RESP/EXEC_*:
  - Dropped, overrun=1 (sticky until reset).
  - This includes a strobe in the same cycle as tx_data_accepted; that byte is dropped, not decoded.
- mem_write_enable is never high outside EXEC_WR.
- mem_address and mem_write_data hold their last values in all other states.
- tx_data_ready never rises in the cycle accepted is seen.
- Back-to-back frames are legal with no gap once IDLE is re-entered.

Test Plan:
- Write then read: send 57 05 01; wait for 'K'; send 52 05 -> mem_write_enable pulses once with addr 5, data 1; then response 0x01; cmd_count=2.
- Bad opcode: send 0x41 -> response 0x3F; no write; state IDLE; the next 52 00 is decoded normally and returns the RAM INIT bit 0.
- Address range: ADDR_WIDTH=6, send 57 40 01 -> response 0x45; no write; the RAM is unchanged when read back.
- Timeout: TIMEOUT_CYCLES=100, send 57 05 then idle 100 cycles, then 52 05 -> only one response, which equals the prior contents of addr 5; no write occurred.
- Overrun and backpressure: hold tx_data_accepted=0 for 50 cycles after a read and inject byte 0x57 -> tx_data_ready held with tx_data stable; overrun=1; that byte is not decoded.
- Reset mid-frame: assert nrst low after 57 05 -> all outputs 0 immediately; after release, 52 05 returns the original value.
